// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multicycle MIPS datapath with configurable memory stall cycles.
// Ports: clk, reset (sync, active-low); opcode/funct/zero from the datapath;
// pcen/irwrite/regwrite/memwrite write enables; alusrca/iord/memtoreg/regdst/alusrcb/pcsrc mux
// selects; alucontrol ALU operation. MEM_WAIT (0..15) adds stall cycles to FETCH, MEMRD, MEMWR.
// Optional macro BNE_EN adds a BNEEX state so bne is executed instead of treated as a no-op.
package mips_decls_p;
    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;
    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_BNE   = 6'b000101;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam funct_t  F_ADD    = 6'b100000;
    localparam funct_t  F_SUB    = 6'b100010;
    localparam funct_t  F_AND    = 6'b100100;
    localparam funct_t  F_OR     = 6'b100101;
    localparam funct_t  F_SLT    = 6'b101010;
endpackage

module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  mips_decls_p::opcode_t opcode,
    input  mips_decls_p::funct_t  funct,
    input  logic                  zero,
    output logic                  pcen,
    output logic                  irwrite,
    output logic                  regwrite,
    output logic                  memwrite,
    output logic                  alusrca,
    output logic                  iord,
    output logic                  memtoreg,
    output logic                  regdst,
    output logic [1:0]            alusrcb,
    output logic [1:0]            pcsrc,
    output logic [2:0]            alucontrol
);
    import mips_decls_p::*;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
        BEQEX, ADDIEX, ADDIWB, JEX
`ifdef BNE_EN
        , BNEEX
`endif
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       done, waiting;
    logic       pcen_r, irwrite_r, regwrite_r, memwrite_r;

    // Stall states leave only on their last cycle, so the counter naturally
    // returns to 0 on every exit and is already 0 on entry.
    assign waiting = state inside {FETCH, MEMRD, MEMWR};
    assign done    = cnt == 4'(MEM_WAIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (waiting && !done) ? cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_next = state;
        pcen_r     = 1'b0;
        irwrite_r  = 1'b0;
        regwrite_r = 1'b0;
        memwrite_r = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (state)
            FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irwrite_r  = done;
                pcen_r     = done;
                state_next = done ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
`ifdef BNE_EN
                    OP_BNE:       state_next = BNEEX;
`endif
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord       = 1'b1;
                state_next = done ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite_r = 1'b1;
                memtoreg   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_r = done;
                state_next = done ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = (funct == F_SUB) ? 3'b110 :
                             (funct == F_AND) ? 3'b000 :
                             (funct == F_OR)  ? 3'b001 :
                             (funct == F_SLT) ? 3'b111 : 3'b010;
                state_next = RTYPEWB;
            end
            RTYPEWB: begin
                regwrite_r = 1'b1;
                regdst     = 1'b1;
                state_next = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen_r     = zero;
                state_next = FETCH;
            end
`ifdef BNE_EN
            BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen_r     = ~zero;
                state_next = FETCH;
            end
`endif
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite_r = 1'b1;
                state_next = FETCH;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcen_r     = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset gates the enables combinationally so nothing is written while it is held.
    assign pcen     = pcen_r & reset;
    assign irwrite  = irwrite_r & reset;
    assign regwrite = regwrite_r & reset;
    assign memwrite = memwrite_r & reset;
endmodule
